// File: rtl/wb_gamepad_poller_if.sv
// Wishbone slave bundle for the gamepad poller.
// Master drives the request, the slave returns registered data/ack.
interface wb_gamepad_poller_if;
  logic        valid;
  logic        we;
  logic [3:0]  adr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (
    output valid, we, adr, wdata,
    input  rdata, ack
  );

  modport slave (
    input  valid, we, adr, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/wb_gamepad_poller.sv
// Autonomous SNES-style gamepad poller with Wishbone register access.
// Shifts up to four pads in parallel and commits button words atomically.
module wb_gamepad_poller #(
  parameter int PLAYERS     = 2,
  parameter int BUTTON_BITS = 12,
  parameter int CLK_DIV     = 4
) (
  input  logic               clk,
  input  logic               reset,
  wb_gamepad_poller_if.slave wb,
  input  logic               frame_tick,
  input  logic [PLAYERS-1:0] pad_data,
  output logic               pad_clk,
  output logic               pad_latch,
  output logic               irq
);
  localparam int CW = $clog2(BUTTON_BITS + 1);
  localparam int DW = $clog2(2 * CLK_DIV + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LATCH, S_HIGH, S_LOW, S_COMMIT
  } state_t;

  typedef logic [BUTTON_BITS-1:0] word_t;

  state_t state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] bit_q, bit_d;
  logic pending_q, pending_d;
  logic auto_en_q, auto_en_d;
  logic irq_en_q, irq_en_d;
  logic done_q, done_d;
  logic ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic [PLAYERS-1:0] sync1_q, sync2_q;
  word_t shift_q [PLAYERS];
  word_t shift_d [PLAYERS];
  word_t buttons_q [PLAYERS];
  word_t buttons_d [PLAYERS];
  word_t pressed_q [PLAYERS];
  word_t pressed_d [PLAYERS];

  logic acc, wr, trig;
  logic sample, commit, busy;

  assign acc  = wb.valid & ~ack_q;
  assign wr   = acc & wb.we;
  assign trig = (wr && wb.adr == 4'd0 && wb.wdata[1])
              || (frame_tick && auto_en_q);

  // State and register file flops
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      pending_q <= 1'b0;
      auto_en_q <= 1'b0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      for (int p = 0; p < PLAYERS; p++) begin
        shift_q[p]   <= '0;
        buttons_q[p] <= '0;
        pressed_q[p] <= '0;
      end
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      pending_q <= pending_d;
      auto_en_q <= auto_en_d;
      irq_en_q  <= irq_en_d;
      done_q    <= done_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      sync1_q   <= pad_data;
      sync2_q   <= sync1_q;
      for (int p = 0; p < PLAYERS; p++) begin
        shift_q[p]   <= shift_d[p];
        buttons_q[p] <= buttons_d[p];
        pressed_q[p] <= pressed_d[p];
      end
    end
  end

  // Poll sequencing: phase timer, bit counter, one-deep pending trigger
  always_comb begin
    state_d   = state_q;
    div_d     = div_q + 1'b1;
    bit_d     = bit_q;
    pending_d = pending_q;
    unique case (state_q)
      S_IDLE: begin
        div_d = '0;
        if (trig) begin
          state_d = S_LATCH;
          bit_d   = '0;
        end
      end
      S_LATCH: begin
        if (trig) pending_d = 1'b1;
        if (div_q == DW'(2 * CLK_DIV - 1)) begin
          state_d = S_HIGH;
          div_d   = '0;
        end
      end
      S_HIGH: begin
        if (trig) pending_d = 1'b1;
        if (div_q == DW'(CLK_DIV - 1)) begin
          state_d = S_LOW;
          div_d   = '0;
        end
      end
      S_LOW: begin
        if (trig) pending_d = 1'b1;
        if (div_q == DW'(CLK_DIV - 1)) begin
          div_d   = '0;
          bit_d   = bit_q + 1'b1;
          state_d = (bit_q == CW'(BUTTON_BITS - 1))
                  ? S_COMMIT : S_HIGH;
        end
      end
      S_COMMIT: begin
        div_d     = '0;
        bit_d     = '0;
        pending_d = 1'b0;
        state_d   = (pending_q || trig) ? S_LATCH : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        div_d   = '0;
      end
    endcase
  end

  // Pad pins and datapath strobes decoded from the current state
  always_comb begin
    pad_clk   = (state_q != S_LOW);
    pad_latch = (state_q == S_LATCH);
    sample    = (state_q == S_HIGH) && (div_q == DW'(CLK_DIV - 1));
    commit    = (state_q == S_COMMIT);
    busy      = (state_q != S_IDLE);
  end

  // Register writes, shifting and commit; a set beats a same-cycle W1C
  always_comb begin
    auto_en_d = auto_en_q;
    irq_en_d  = irq_en_q;
    done_d    = done_q;
    for (int p = 0; p < PLAYERS; p++) begin
      shift_d[p]   = shift_q[p];
      buttons_d[p] = buttons_q[p];
      pressed_d[p] = pressed_q[p];
    end
    if (wr && wb.adr == 4'd0) begin
      auto_en_d = wb.wdata[0];
      irq_en_d  = wb.wdata[2];
    end
    if (wr && wb.adr == 4'd1 && wb.wdata[0]) done_d = 1'b0;
    for (int p = 0; p < PLAYERS; p++) begin
      if (wr && wb.adr == 4'(8 + p))
        pressed_d[p] = pressed_q[p] & ~wb.wdata[BUTTON_BITS-1:0];
      if (sample) shift_d[p][bit_q] = ~sync2_q[p];
      if (commit) begin
        buttons_d[p] = shift_q[p];
        pressed_d[p] = pressed_d[p] | (shift_q[p] & ~buttons_q[p]);
      end
    end
    if (commit) done_d = 1'b1;
  end

  // Bus response: one-cycle ack, read data captured at request time
  always_comb begin
    ack_d   = acc;
    rdata_d = '0;
    if (acc) begin
      if (wb.adr == 4'd0)
        rdata_d = {27'b0, pending_q, busy, irq_en_q, 1'b0, auto_en_q};
      if (wb.adr == 4'd1)
        rdata_d = {31'b0, done_q};
      for (int p = 0; p < PLAYERS; p++) begin
        if (wb.adr == 4'(4 + p)) rdata_d = 32'(buttons_q[p]);
        if (wb.adr == 4'(8 + p)) rdata_d = 32'(pressed_q[p]);
      end
    end
  end

  assign wb.ack   = ack_q;
  assign wb.rdata = rdata_q;
  assign irq      = done_q & irq_en_q;

endmodule

// File: tb/tb_wb_gamepad_poller.sv
// Bench for wb_gamepad_poller: vector table, random polls vs model,
// and hand sequences for pending restart, W1C race and mid-poll reset.
module tb_wb_gamepad_poller;
  localparam int PLAYERS = 2;
  localparam int BB      = 12;
  localparam int CDIV    = 4;
  localparam int POLL_LEN = 2 * CDIV * (BB + 1) + 1;

  logic clk = 1'b0;
  logic reset;
  logic frame_tick;
  logic [PLAYERS-1:0] pad_data;
  logic pad_clk, pad_latch, irq;

  wb_gamepad_poller_if bus ();

  wb_gamepad_poller #(
    .PLAYERS(PLAYERS), .BUTTON_BITS(BB), .CLK_DIV(CDIV)
  ) dut (
    .clk(clk), .reset(reset), .wb(bus.slave),
    .frame_tick(frame_tick), .pad_data(pad_data),
    .pad_clk(pad_clk), .pad_latch(pad_latch), .irq(irq)
  );

  always #5 clk = ~clk;

  // Pad model: latch reloads, each pad_clk rise advances one button
  logic [BB-1:0] pad_btn [PLAYERS];
  int idx = 0;
  always @(posedge pad_clk or posedge pad_latch) begin
    if (pad_latch) idx <= 0;
    else idx <= idx + 1;
  end
  always_comb begin
    for (int p = 0; p < PLAYERS; p++)
      pad_data[p] = (idx < BB) ? ~pad_btn[p][idx[3:0]] : 1'b1;
  end

  // Pin monitor on the falling edge
  int cyc = 0, lat_start = 0, lat_len = 0, pulses = 0;
  int poll_len = 0, irq_rises = 0;
  logic latch_p = 1'b0, clk_p = 1'b1, irq_p = 1'b0;
  logic latch_at_irq = 1'b0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (irq && !irq_p) begin
      poll_len     <= cyc - lat_start;
      latch_at_irq <= pad_latch;
      irq_rises    <= irq_rises + 1;
    end
    if (pad_latch && !latch_p) begin
      lat_start <= cyc;
      lat_len   <= 1;
      pulses    <= 0;
    end else if (pad_latch) lat_len <= lat_len + 1;
    else if (!pad_clk && clk_p) pulses <= pulses + 1;
    latch_p <= pad_latch;
    clk_p   <= pad_clk;
    irq_p   <= irq;
  end

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb_rw(input logic we, input logic [3:0] adr,
                       input logic [31:0] wd, output logic [31:0] rd);
    bus.valid = 1'b1;
    bus.we    = we;
    bus.adr   = adr;
    bus.wdata = wd;
    wait_cyc(1);
    chk("ack_rise", 32'(bus.ack), 32'd1);
    rd = bus.rdata;
    bus.valid = 1'b0;
    bus.we    = 1'b0;
    wait_cyc(1);
    chk("ack_fall", 32'(bus.ack), 32'd0);
  endtask

  task automatic wr(input logic [3:0] adr, input logic [31:0] wd);
    logic [31:0] d;
    wb_rw(1'b1, adr, wd, d);
  endtask

  task automatic rd_chk(input string nm, input logic [3:0] adr,
                        input logic [31:0] exp);
    logic [31:0] d;
    wb_rw(1'b0, adr, 32'h0, d);
    chk(nm, d, exp);
  endtask

  task automatic wait_irq();
    int base;
    int n;
    base = irq_rises;
    n = 0;
    while (irq_rises == base && n < 400) begin
      wait_cyc(1);
      n++;
    end
    chk("irq_wait", 32'(irq_rises != base), 32'd1);
  endtask

  task automatic do_poll(input logic [31:0] ctrl);
    wr(4'd0, ctrl);
    wait_irq();
    chk("poll_len", 32'(poll_len), 32'(POLL_LEN));
    chk("latch_len", 32'(lat_len), 32'(2 * CDIV));
    chk("clk_pulses", 32'(pulses), 32'(BB));
  endtask

  // Reference: BUTTONS follows the pads, PRESSED collects 0->1 edges
  logic [BB-1:0] mb [PLAYERS];
  logic [BB-1:0] mp [PLAYERS];

  task automatic model_poll();
    for (int p = 0; p < PLAYERS; p++) begin
      mp[p] = mp[p] | (pad_btn[p] & ~mb[p]);
      mb[p] = pad_btn[p];
    end
  endtask

  typedef struct {
    logic [BB-1:0] p0, p1, clr0;
    logic [31:0]   b0, b1, pr0, pr1, pr0_after;
  } vec_t;
  vec_t tbl [4];

  initial begin
    logic [31:0] m;
    logic [31:0] d;

    tbl[0] = '{12'h005, 12'h800, 12'h000,
               32'h005, 32'h800, 32'h005, 32'h800, 32'h005};
    tbl[1] = '{12'h00C, 12'h800, 12'h001,
               32'h00C, 32'h800, 32'h00D, 32'h800, 32'h00C};
    tbl[2] = '{12'h000, 12'h001, 12'hFFF,
               32'h000, 32'h001, 32'h00C, 32'h801, 32'h000};
    tbl[3] = '{12'hFFF, 12'h000, 12'h0F0,
               32'hFFF, 32'h000, 32'hFFF, 32'h801, 32'hF0F};

    for (int p = 0; p < PLAYERS; p++) begin
      pad_btn[p] = '0;
      mb[p] = '0;
      mp[p] = '0;
    end
    reset = 1'b1;
    frame_tick = 1'b0;
    bus.valid = 1'b0;
    bus.we = 1'b0;
    bus.adr = '0;
    bus.wdata = '0;
    wait_cyc(3);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_padclk", 32'(pad_clk), 32'd1);
    chk("rst_latch", 32'(pad_latch), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    reset = 1'b0;
    wait_cyc(1);
    rd_chk("rst_ctrl", 4'd0, 32'h0);
    rd_chk("rst_status", 4'd1, 32'h0);
    rd_chk("rst_btn0", 4'd4, 32'h0);
    rd_chk("rst_btn1", 4'd5, 32'h0);

    // Table-driven polls
    for (int i = 0; i < 4; i++) begin
      pad_btn[0] = tbl[i].p0;
      pad_btn[1] = tbl[i].p1;
      do_poll(32'h6);
      model_poll();
      rd_chk("tbl_ctrl", 4'd0, 32'h4);
      rd_chk("tbl_status", 4'd1, 32'h1);
      rd_chk("tbl_btn0", 4'd4, tbl[i].b0);
      rd_chk("tbl_btn1", 4'd5, tbl[i].b1);
      rd_chk("tbl_prs0", 4'd8, tbl[i].pr0);
      rd_chk("tbl_prs1", 4'd9, tbl[i].pr1);
      wr(4'd1, 32'h1);
      chk("tbl_irq_clr", 32'(irq), 32'd0);
      wr(4'd8, 32'(tbl[i].clr0));
      mp[0] = mp[0] & ~tbl[i].clr0;
      rd_chk("tbl_prs0_w1c", 4'd8, tbl[i].pr0_after);
    end

    // Random polls against the model
    for (int i = 0; i < 8; i++) begin
      for (int p = 0; p < PLAYERS; p++)
        pad_btn[p] = BB'($urandom_range(0, (1 << BB) - 1));
      do_poll(32'h6);
      model_poll();
      for (int p = 0; p < PLAYERS; p++) begin
        rd_chk("rnd_btn", 4'(4 + p), 32'(mb[p]));
        rd_chk("rnd_prs", 4'(8 + p), 32'(mp[p]));
      end
      wr(4'd1, 32'h1);
      for (int p = 0; p < PLAYERS; p++) begin
        m = $urandom;
        wr(4'(8 + p), m);
        mp[p] = mp[p] & ~m[BB-1:0];
        rd_chk("rnd_prs_w1c", 4'(8 + p), 32'(mp[p]));
      end
    end

    // Auto mode, frame_tick trigger, pending restart
    wr(4'd0, 32'h5);
    frame_tick = 1'b1;
    wait_cyc(1);
    frame_tick = 1'b0;
    wait_irq();
    model_poll();
    chk("auto_len", 32'(poll_len), 32'(POLL_LEN));
    rd_chk("auto_ctrl", 4'd0, 32'h5);
    wr(4'd1, 32'h1);
    chk("auto_irq_clr", 32'(irq), 32'd0);
    frame_tick = 1'b1;
    wait_cyc(1);
    frame_tick = 1'b0;
    wait_cyc(20);
    rd_chk("busy_ctrl", 4'd0, 32'h0D);
    frame_tick = 1'b1;
    wait_cyc(1);
    frame_tick = 1'b0;
    rd_chk("pend_ctrl", 4'd0, 32'h1D);
    wait_irq();
    model_poll();
    chk("pend_restart", 32'(latch_at_irq), 32'd1);
    wr(4'd1, 32'h1);
    wait_irq();
    model_poll();
    chk("pend_len", 32'(poll_len), 32'(POLL_LEN));
    rd_chk("pend_done_ctrl", 4'd0, 32'h5);
    wr(4'd0, 32'h4);
    wr(4'd1, 32'h1);
    for (int p = 0; p < PLAYERS; p++) begin
      rd_chk("auto_btn", 4'(4 + p), 32'(mb[p]));
      rd_chk("auto_prs", 4'(8 + p), 32'(mp[p]));
    end

    // W1C of done landing on the commit edge loses to the set
    wr(4'd0, 32'h6);
    wait_cyc(POLL_LEN - 2);
    wr(4'd1, 32'h1);
    model_poll();
    chk("w1c_race_irq", 32'(irq), 32'd1);
    rd_chk("w1c_race_st", 4'd1, 32'h1);
    wr(4'd1, 32'h1);
    chk("w1c_after", 32'(irq), 32'd0);

    // Unmapped reads and ack under continuous valid
    rd_chk("unmap3", 4'd3, 32'h0);
    rd_chk("unmap_btn3", 4'd7, 32'h0);
    rd_chk("unmap_prs2", 4'd10, 32'h0);
    rd_chk("unmap15", 4'd15, 32'h0);
    wr(4'd3, 32'hFFFF_FFFF);
    rd_chk("unmap_wr_ctrl", 4'd0, 32'h4);
    bus.valid = 1'b1;
    bus.we = 1'b0;
    bus.adr = 4'd3;
    for (int i = 0; i < 6; i++) begin
      wait_cyc(1);
      chk("ack_seq", 32'(bus.ack), 32'((i % 2) == 0));
      if (bus.ack) chk("ack_seq_rd", bus.rdata, 32'h0);
    end
    bus.valid = 1'b0;
    wait_cyc(2);

    // Reset in the middle of shifting
    wr(4'd0, 32'h0);
    pad_btn[0] = 12'h3AA;
    pad_btn[1] = 12'h155;
    wr(4'd0, 32'h6);
    wait_cyc(40);
    reset = 1'b1;
    wait_cyc(2);
    chk("midrst_padclk", 32'(pad_clk), 32'd1);
    chk("midrst_latch", 32'(pad_latch), 32'd0);
    chk("midrst_irq", 32'(irq), 32'd0);
    reset = 1'b0;
    wait_cyc(150);
    chk("midrst_irq_late", 32'(irq), 32'd0);
    chk("midrst_latch_late", 32'(pad_latch), 32'd0);
    rd_chk("midrst_btn0", 4'd4, 32'h0);
    rd_chk("midrst_btn1", 4'd5, 32'h0);
    rd_chk("midrst_prs0", 4'd8, 32'h0);
    rd_chk("midrst_status", 4'd1, 32'h0);
    rd_chk("midrst_ctrl", 4'd0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/wb_gamepad_poller.md
# wb_gamepad_poller

Wishbone-slave gamepad controller that autonomously polls up to four serial (SNES-style latch/clock/data) gamepads and presents debounced-by-frame button state to the management CPU. It replaces CPU bit-banging of the gamepad clock/latch pins in the user project: the CPU triggers a poll, or the poller runs once per video frame, and reads complete button words over Wishbone. It sits beside the VDP in the user-project address decode at page 0x3020_xxxx.

## Interface
- PLAYERS, 2: number of pads (1..4); one pad_data input each, shared pad_clk/pad_latch.
- BUTTON_BITS, 12: bits shifted per pad per poll (1..32).
- CLK_DIV, 4: clk cycles per pad_clk half-period (≥4, guarantees synchroniser settling).

- clk  in  1  system clock (wb_clk_i).
- reset  in  1  synchronous, active-high.
- wb_valid  in  1  cyc && stb, already qualified by page decode.
- wb_we  in  1  write strobe (any sel bit set).
- wb_adr  in  4  word address, byte address bits [5:2].
- wb_wdata  in  32  write data.
- wb_rdata  out  32  read data, registered.
- wb_ack  out  1  single-cycle acknowledge.
- frame_tick  in  1  one-cycle pulse per frame (VDP frame_ended).
- pad_data  in  PLAYERS  serial data, active-low buttons, asynchronous.
- pad_clk  out  1  shared pad clock, idles high.
- pad_latch  out  1  shared latch, active-high.
- irq  out  1  done && irq_en.

## Operation
- Register map (word index): 0 CTRL, 1 STATUS, 4+p BUTTONS[p], 8+p PRESSED[p], p < PLAYERS; all else reads 0, writes ignored, still acked.
- CTRL: bit0 auto_en (RW), bit1 start (W, self-clearing, reads 0), bit2 irq_en (RW), bit3 busy (RO), bit4 pending (RO).
- STATUS: bit0 done, sticky, write-1-to-clear.
- BUTTONS[p]: [BUTTON_BITS-1:0] last completed poll, active-high (pad_data inverted), bit i = i-th bit shifted; upper bits 0; RO.
- PRESSED[p]: sticky newly-pressed bits, set where new=1 and old BUTTONS=0 at commit; W1C.
- Triggers: write CTRL with bit1=1, or frame_tick while auto_en=1.
- pad_data passes a 2-flop synchroniser per player before sampling.
- FSM states: IDLE, LATCH, HIGH, LOW, COMMIT.
- IDLE: pad_clk=1, pad_latch=0; trigger -> LATCH next cycle, bit counter=0.
- LATCH: pad_latch=1, pad_clk=1 for 2*CLK_DIV cycles -> HIGH.
- HIGH: pad_clk=1, CLK_DIV cycles; last cycle samples synchronised pad_data into shift register bit [counter] -> LOW.
- LOW: pad_clk=0, CLK_DIV cycles; counter+1; if counter was BUTTON_BITS-1 -> COMMIT else -> HIGH.
- COMMIT: one cycle; all BUTTONS/PRESSED update atomically, done set; -> LATCH if pending (pending cleared) else IDLE.
- Trigger when not IDLE sets pending (one deep; further triggers merge). Trigger in COMMIT counts as pending.
- Simultaneous set and W1C (done or PRESSED bit) in same cycle: set wins.
- Reset: all state to IDLE, every register 0, pad_clk=1, pad_latch=0, wb_ack=0, wb_rdata=0, irq=0; reset mid-poll discards the partial shift.

## Timing
- wb_ack: asserted the cycle after wb_valid when wb_ack was 0; deasserted the next cycle; never two consecutive cycles. Writes take effect at the ack edge.
- wb_rdata valid in the ack cycle; reflects register state at the cycle wb_valid was sampled.
- Trigger at edge T -> pad_latch high from T+1.
- Poll length latch-rise to done visible: 2*CLK_DIV*(BUTTON_BITS+1)+1 cycles (defaults: 105).
- Sampling point: CLK_DIV-1 cycles after pad_clk rise, i.e. ≥3 cycles past synchroniser input.
- irq combinational from registered done/irq_en; rises the cycle after COMMIT.
- Pending restart: pad_latch rises the cycle after COMMIT, no IDLE cycle.

## Test plan
- Reset, then read CTRL, STATUS, BUTTONS[0..1] -> all 0x0000_0000; pad_clk=1, pad_latch=0.
- Pad model P0 presses 0x005 (bits 0,2), P1 0x800; write CTRL=0x2 -> pad_latch high 8 cycles, 12 clock pulses, done after 105 cycles; BUTTONS[0]=0x005, BUTTONS[1]=0x800, PRESSED equal.
- Second poll with P0=0x00C -> BUTTONS[0]=0x00C, PRESSED[0]=0x00D; write PRESSED[0]=0x001 -> reads 0x00C.
- auto_en=1, irq_en=1, frame_tick pulse -> one poll, irq=1; write STATUS=1 -> irq=0; frame_tick during poll -> pending=1, second latch starts the cycle after COMMIT.
- W1C of done in the COMMIT cycle -> done stays 1; reset asserted mid-SHIFT -> pad_clk=1, pad_latch=0, BUTTONS unchanged at 0, no irq.
- Read unmapped word 3 and BUTTONS[3] with PLAYERS=2 -> 0x0000_0000, ack one cycle, no back-to-back ack under continuous wb_valid.
